// File: rtl/magcompare_tree_pipe.sv
// Pipelined WIDTH-bit magnitude comparator: 2-bit leaf compares merged by a
// registered binary tree, one register rank per combine level, valid/ready on both sides.
module magcompare_tree_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic             valid_out,
    input  logic             ready_out,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int G  = WIDTH / 2;          // number of 2-bit leaf groups
    localparam int L  = $clog2(WIDTH) - 1;  // combine levels == register ranks
    localparam int NP = G - 1;              // total (lt,gt) pairs over all ranks

    // All ranks share one flat vector: rank s holds G>>s pairs starting here.
    function automatic int level_base(input int s);
        return G - (G >> (s - 1));
    endfunction

    logic [WIDTH-1:0] a_m, b_m;
    logic [G-1:0]     leaf_lt, leaf_gt;
    logic [NP-1:0]    lt_d, gt_d;
    logic [NP-1:0]    lt_q, gt_q;
    logic [L-1:0]     vld_q;
    logic [L-1:0]     load;
    logic             eq_q;
    logic             advance;

    // Offset-binary: flipping the sign bits turns a signed compare into an unsigned one.
    always_comb begin
        a_m            = a;
        b_m            = b;
        a_m[WIDTH-1]   = a[WIDTH-1] ^ sgn;
        b_m[WIDTH-1]   = b[WIDTH-1] ^ sgn;
    end

    always_comb begin
        leaf_lt = '0;
        leaf_gt = '0;
        for (int i = 0; i < G; i++) begin
            leaf_lt[i] = (~a_m[2*i+1] &  b_m[2*i+1])
                       | (~a_m[2*i+1] & ~a_m[2*i] &  b_m[2*i])
                       | (~a_m[2*i]   &  b_m[2*i+1] &  b_m[2*i]);
            leaf_gt[i] = ( a_m[2*i+1] & ~b_m[2*i+1])
                       | ( a_m[2*i+1] &  a_m[2*i] & ~b_m[2*i])
                       | ( a_m[2*i]   & ~b_m[2*i+1] & ~b_m[2*i]);
        end
    end

    // Next-state for every rank: level 1 from the leaves, level s from rank s-1.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lt_d = '0;
        gt_d = '0;
        for (int i = 0; i < G / 2; i++) begin
            gt_d[i] = leaf_gt[2*i+1] | (~leaf_lt[2*i+1] & leaf_gt[2*i]);
            lt_d[i] = leaf_lt[2*i+1] | (~leaf_gt[2*i+1] & leaf_lt[2*i]);
        end
        for (int s = 2; s <= L; s++) begin
            for (int i = 0; i < (G >> s); i++) begin
                gt_d[level_base(s) + i] = gt_q[level_base(s-1) + 2*i + 1]
                    | (~lt_q[level_base(s-1) + 2*i + 1] & gt_q[level_base(s-1) + 2*i]);
                lt_d[level_base(s) + i] = lt_q[level_base(s-1) + 2*i + 1]
                    | (~gt_q[level_base(s-1) + 2*i + 1] & lt_q[level_base(s-1) + 2*i]);
            end
        end
    end

    assign advance  = ~vld_q[L-1] | ready_out;
    assign ready_in = advance;

    // A rank only captures data when a valid item moves into it, so bubbles
    // never disturb the held result.
    always_comb begin
        load    = '0;
        load[0] = advance & valid_in;
        for (int s = 2; s <= L; s++) begin
            load[s-1] = advance & vld_q[s-2];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every rank samples
    // the pre-edge value of the rank before it.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: only valid bits and the visible result are reset; intermediate
            // pair registers are qualified by their valid bits and need no reset.
            vld_q      <= '0;
            lt_q[NP-1] <= 1'b0;
            gt_q[NP-1] <= 1'b0;
            eq_q       <= 1'b0;
        end else begin
            if (advance) begin
                vld_q <= (vld_q << 1) | L'(valid_in);
            end
            for (int s = 1; s <= L; s++) begin
                if (load[s-1]) begin
                    for (int i = 0; i < (G >> s); i++) begin
                        lt_q[level_base(s) + i] <= lt_d[level_base(s) + i];
                        gt_q[level_base(s) + i] <= gt_d[level_base(s) + i];
                    end
                end
            end
            if (load[L-1]) begin
                eq_q <= ~lt_d[NP-1] & ~gt_d[NP-1];
            end
        end
    end

    assign valid_out = vld_q[L-1];
    assign lt        = lt_q[NP-1];
    assign gt        = gt_q[NP-1];
    assign eq        = eq_q;

endmodule

// File: tb/tb_magcompare_tree_pipe.sv
// Self-checking bench for magcompare_tree_pipe (WIDTH=16): directed vector table,
// back-pressure and mid-flight reset sequences, then a randomized scoreboard run.
module tb_magcompare_tree_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_in;
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic        valid_out;
    logic        ready_out;
    logic        lt;
    logic        gt;
    logic        eq;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sgn;
        logic        lt;
        logic        gt;
        logic        eq;
    } vec_t;

    vec_t       vecs [12];
    logic [2:0] sb_q [$];

    magcompare_tree_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .lt        (lt),
        .gt        (gt),
        .eq        (eq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic l, g;
        if (s) begin
            l = $signed(x) < $signed(y);
            g = $signed(x) > $signed(y);
        end else begin
            l = x < y;
            g = x > y;
        end
        return {l, g, ~l & ~g};
    endfunction

    initial begin
        vecs[0]  = '{16'h1234, 16'h1235, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'hA5A5, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{16'hA5A5, 16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{16'h4000, 16'h3FFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{16'h8000, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; valid_in = 1'b0; a = '0; b = '0; sgn = 1'b0; ready_out = 1'b1;

        // Reset state
        step(); step();
        check("reset valid_out", valid_out, 0);
        check("reset lt", lt, 0);
        check("reset gt", gt, 0);
        check("reset eq", eq, 0);
        check("reset ready_in", ready_in, 1);
        reset = 1'b0;
        step();

        // Directed table: single-cycle valid, exact latency, single-cycle result
        for (int k = 0; k < 12; k++) begin
            a = vecs[k].a; b = vecs[k].b; sgn = vecs[k].sgn; valid_in = 1'b1;
            step();
            valid_in = 1'b0;
            check($sformatf("vec%0d early0", k), valid_out, 0);
            step();
            check($sformatf("vec%0d early1", k), valid_out, 0);
            step();
            check($sformatf("vec%0d valid", k), valid_out, 1);
            check($sformatf("vec%0d ltgteq", k), {lt, gt, eq}, {vecs[k].lt, vecs[k].gt, vecs[k].eq});
            step();
            check($sformatf("vec%0d single", k), valid_out, 0);
        end

        // Back-pressure: three back-to-back items, stall 4 cycles on the first result
        a = 16'h0005; b = 16'h0003; sgn = 1'b0; valid_in = 1'b1;
        step();
        a = 16'h0003;
        step();
        a = 16'h0001;
        step();
        valid_in = 1'b0;
        ready_out = 1'b0;
        #1;
        check("bp first valid", valid_out, 1);
        check("bp ready_in low", ready_in, 0);
        check("bp first gt", {lt, gt, eq}, 3'b010);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("bp hold%0d ready_in", c), ready_in, 0);
            check($sformatf("bp hold%0d valid", c), valid_out, 1);
            check($sformatf("bp hold%0d gt", c), {lt, gt, eq}, 3'b010);
        end
        ready_out = 1'b1;
        step();
        check("bp second valid", valid_out, 1);
        check("bp second eq", {lt, gt, eq}, 3'b001);
        step();
        check("bp third valid", valid_out, 1);
        check("bp third lt", {lt, gt, eq}, 3'b100);
        step();
        check("bp drained", valid_out, 0);

        // Reset with two transactions in flight
        a = 16'h0001; b = 16'h0002; sgn = 1'b0; valid_in = 1'b1;
        step();
        a = 16'h0009;
        step();
        valid_in = 1'b0;
        reset = 1'b1;
        step();
        check("midreset valid_out", valid_out, 0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("midreset quiet%0d", c), valid_out, 0);
        end

        // Random stream with random back-pressure against the reference model
        begin
            logic pending;
            pending = 1'b0;
            for (int c = 0; c < 10000; c++) begin
                if (!pending) begin
                    valid_in = ($urandom_range(3) != 0);
                    a = 16'($urandom);
                    b = ($urandom_range(7) == 0) ? a : 16'($urandom);
                    sgn = 1'($urandom_range(1));
                end
                ready_out = ($urandom_range(3) != 0);
                #1;
                if (valid_out && ready_out) begin
                    if (sb_q.size() == 0) begin
                        check("rand unexpected output", 1, 0);
                    end else begin
                        check("rand result", {lt, gt, eq}, sb_q.pop_front());
                    end
                end
                if (valid_in && ready_in) begin
                    sb_q.push_back(model(a, b, sgn));
                end
                pending = valid_in && !ready_in;
                step();
            end
            valid_in = 1'b0;
            ready_out = 1'b1;
            for (int c = 0; c < 20 && sb_q.size() != 0; c++) begin
                #1;
                if (valid_out) begin
                    check("drain result", {lt, gt, eq}, sb_q.pop_front());
                end
                step();
            end
            check("scoreboard empty", sb_q.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
